// File: rtl/act_mem_banked_ctrl.sv
// Banked activation-memory controller: arbitrates engine/streamer reads and writes
// over NUM_BANKS single-port banks, with an RF-backed low region of bank 0 and a read hold register.
module act_mem_banked_ctrl #(
  parameter int NUM_BANKS  = 2,
  parameter int LANES      = 4,
  parameter int DATA_W     = 8,
  parameter int BANK_DEPTH = 128,
  parameter int RF_DEPTH   = 64,
  parameter int CNT_W      = 32,
  localparam int BANK_BITS = $clog2(NUM_BANKS),
  localparam int ROW_W     = $clog2(BANK_DEPTH),
  localparam int LANE_W    = $clog2(LANES),
  localparam int ADDR_W    = BANK_BITS + ROW_W + LANE_W,
  localparam int ROW_DW    = LANES * DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en_in,
  input  logic              int_rd_valid,
  output logic              int_rd_ready,
  input  logic [ADDR_W-1:0] int_rd_addr,
  input  logic              ext_rd_valid,
  output logic              ext_rd_ready,
  input  logic [ADDR_W-1:0] ext_rd_addr,
  input  logic              int_wr_valid,
  output logic              int_wr_ready,
  input  logic [ADDR_W-1:0] int_wr_addr,
  input  logic [ROW_DW-1:0] int_wr_data,
  input  logic [LANES-1:0]  int_wr_mask,
  input  logic              ext_wr_valid,
  output logic              ext_wr_ready,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [ROW_DW-1:0] ext_wr_data,
  input  logic [LANES-1:0]  ext_wr_mask,
  output logic              rd_rvalid,
  output logic              rd_rsrc,
  output logic [ROW_DW-1:0] rd_data,
  output logic [ROW_DW-1:0] ext_rd_data,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt_access,
  output logic [CNT_W-1:0]  cnt_skip,
  output logic              addr_err
);

  localparam int BW    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int RF_N  = (RF_DEPTH > 0) ? RF_DEPTH : 1;
  localparam int RF_AW = (RF_N > 1) ? $clog2(RF_N) : 1;

  typedef enum logic [1:0] {SEL_ZERO, SEL_HOLD, SEL_RF, SEL_SRAM} sel_t;

  function automatic logic [BW-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return BW'(a >> (ROW_W + LANE_W));
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return ROW_W'(a >> LANE_W);
  endfunction

  function automatic logic bank_ok(input logic [BW-1:0] b);
    return int'(b) < NUM_BANKS;
  endfunction

  function automatic logic is_rf(input logic [BW-1:0] b, input logic [ROW_W-1:0] r);
    return (b == '0) && (int'(r) < RF_DEPTH);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W+1:0] s;
    s = (CNT_W+2)'(c) + (CNT_W+2)'(inc);
    return (s[CNT_W+1:CNT_W] != 2'b00) ? '1 : s[CNT_W-1:0];
  endfunction

  logic [BW-1:0]    ewb, iwb, erb, irb, rb, hold_bank;
  logic [ROW_W-1:0] ewr, iwr, err_row, irr, rr, hold_row;
  logic             ext_wr_go, int_wr_go, rd_ext, rd_go, rd_ok, rd_skip, rd_rf, rd_sram;
  logic             ew_ok, iw_ok, ew_rf, iw_rf, ew_sram, iw_sram, wr_inval;
  logic [1:0]       acc_inc;
  logic             rvalid_q, rsrc_q, hold_vld;
  sel_t             sel_q;
  logic [ROW_DW-1:0] rf [RF_N];
  logic [ROW_DW-1:0] mem [NUM_BANKS][BANK_DEPTH];
  logic [ROW_DW-1:0] rf_q, sram_q, rd_last, rd_mux;

  assign ewb = bank_of(ext_wr_addr);
  assign iwb = bank_of(int_wr_addr);
  assign erb = bank_of(ext_rd_addr);
  assign irb = bank_of(int_rd_addr);
  assign ewr = row_of(ext_wr_addr);
  assign iwr = row_of(int_wr_addr);
  assign err_row = row_of(ext_rd_addr);
  assign irr = row_of(int_rd_addr);

  // Handshake: a request transfers on a clock edge where valid && ready; ready is a
  // function of valids and addresses only and is forced low while reset is high.
  always_comb begin
    ext_wr_ready = !reset;
    int_wr_ready = !reset && !(ext_wr_valid && (ewb == iwb));
    ext_wr_go    = ext_wr_valid && ext_wr_ready;
    int_wr_go    = int_wr_valid && int_wr_ready;
    ext_rd_ready = !reset && !((ext_wr_go && ewb == erb) || (int_wr_go && iwb == erb));
    int_rd_ready = !reset && !ext_rd_valid &&
                   !((ext_wr_go && ewb == irb) || (int_wr_go && iwb == irb));
    rd_ext   = ext_rd_valid && ext_rd_ready;
    rd_go    = rd_ext || (int_rd_valid && int_rd_ready);
    rb       = rd_ext ? erb : irb;
    rr       = rd_ext ? err_row : irr;
    rd_ok    = rd_go && bank_ok(rb);
    rd_skip  = rd_ok && hold_vld && (hold_bank == rb) && (hold_row == rr);
    rd_rf    = rd_ok && !rd_skip && is_rf(rb, rr);
    rd_sram  = rd_ok && !rd_skip && !is_rf(rb, rr);
    ew_ok    = ext_wr_go && bank_ok(ewb);
    iw_ok    = int_wr_go && bank_ok(iwb);
    ew_rf    = ew_ok && is_rf(ewb, ewr);
    iw_rf    = iw_ok && is_rf(iwb, iwr);
    ew_sram  = ew_ok && !is_rf(ewb, ewr);
    iw_sram  = iw_ok && !is_rf(iwb, iwr);
    acc_inc  = 2'(rd_rf || rd_sram) + 2'(ew_ok) + 2'(iw_ok);
    wr_inval = (ew_ok && (|ext_wr_mask) && ewb == hold_bank && ewr == hold_row) ||
               (iw_ok && (|int_wr_mask) && iwb == hold_bank && iwr == hold_row);
  end

  // The hold register's data is simply the last value returned on rd_data.
  always_comb begin
    rd_mux = '0;
    case (sel_q)
      SEL_HOLD: rd_mux = rd_last;
      SEL_RF:   rd_mux = rf_q;
      SEL_SRAM: rd_mux = sram_q;
      default:  rd_mux = '0;
    endcase
  end

  assign rd_rvalid   = rvalid_q && !reset;
  assign rd_rsrc     = rsrc_q;
  assign rd_data     = reset ? '0 : (rvalid_q ? rd_mux : rd_last);
  assign ext_rd_data = (rd_rvalid && rd_rsrc) ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q   <= 1'b0;
      rsrc_q     <= 1'b0;
      sel_q      <= SEL_ZERO;
      rd_last    <= '0;
      rf_q       <= '0;
      hold_vld   <= 1'b0;
      hold_bank  <= '0;
      hold_row   <= '0;
      addr_err   <= 1'b0;
      cnt_access <= '0;
      cnt_skip   <= '0;
      for (int i = 0; i < RF_N; i++) rf[i] <= '0;
    end else begin
      rvalid_q <= rd_go;
      if (rd_go) begin
        rsrc_q <= rd_ext;
        sel_q  <= rd_skip ? SEL_HOLD : rd_rf ? SEL_RF : rd_sram ? SEL_SRAM : SEL_ZERO;
      end
      if (rvalid_q) rd_last <= rd_mux;
      if (rd_rf) rf_q <= rf[RF_AW'(rr)];
      if (wr_inval) hold_vld <= 1'b0;
      // An error read returns zeros, so it must not leave a stale hold entry behind.
      if (rd_go) begin
        hold_vld  <= rd_ok;
        hold_bank <= rb;
        hold_row  <= rr;
      end
      for (int l = 0; l < LANES; l++) begin
        if (ew_rf && ext_wr_mask[l]) rf[RF_AW'(ewr)][l*DATA_W +: DATA_W] <= ext_wr_data[l*DATA_W +: DATA_W];
        if (iw_rf && int_wr_mask[l]) rf[RF_AW'(iwr)][l*DATA_W +: DATA_W] <= int_wr_data[l*DATA_W +: DATA_W];
      end
      addr_err   <= (rd_go && !rd_ok) || (ext_wr_go && !ew_ok) || (int_wr_go && !iw_ok);
      cnt_access <= cnt_clear ? '0 : sat_add(cnt_access, acc_inc);
      cnt_skip   <= cnt_clear ? '0 : sat_add(cnt_skip, 2'(rd_skip));
    end
  end

  // Behavioural SRAM macros; chip enables are held off while scan is active.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (ew_sram && !scan_en_in && ext_wr_mask[l]) mem[ewb][ewr][l*DATA_W +: DATA_W] <= ext_wr_data[l*DATA_W +: DATA_W];
      if (iw_sram && !scan_en_in && int_wr_mask[l]) mem[iwb][iwr][l*DATA_W +: DATA_W] <= int_wr_data[l*DATA_W +: DATA_W];
    end
    if (rd_sram && !scan_en_in) sram_q <= mem[rb][rr];
  end

endmodule

// File: tb/tb_act_mem_banked_ctrl.sv
// Directed bench for act_mem_banked_ctrl with three banks and 4-bit counters,
// so invalid-bank handling and counter saturation are both reachable.
module tb_act_mem_banked_ctrl;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk, reset, scan_en_in, cnt_clear;
  logic          int_rd_valid, int_rd_ready, ext_rd_valid, ext_rd_ready;
  logic [AW-1:0] int_rd_addr, ext_rd_addr, int_wr_addr, ext_wr_addr;
  logic          int_wr_valid, int_wr_ready, ext_wr_valid, ext_wr_ready;
  logic [DW-1:0] int_wr_data, ext_wr_data, rd_data, ext_rd_data;
  logic [3:0]    int_wr_mask, ext_wr_mask;
  logic          rd_rvalid, rd_rsrc, addr_err;
  logic [CW-1:0] cnt_access, cnt_skip;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  act_mem_banked_ctrl #(.NUM_BANKS(3), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .scan_en_in(scan_en_in),
    .int_rd_valid(int_rd_valid), .int_rd_ready(int_rd_ready), .int_rd_addr(int_rd_addr),
    .ext_rd_valid(ext_rd_valid), .ext_rd_ready(ext_rd_ready), .ext_rd_addr(ext_rd_addr),
    .int_wr_valid(int_wr_valid), .int_wr_ready(int_wr_ready), .int_wr_addr(int_wr_addr),
    .int_wr_data(int_wr_data), .int_wr_mask(int_wr_mask),
    .ext_wr_valid(ext_wr_valid), .ext_wr_ready(ext_wr_ready), .ext_wr_addr(ext_wr_addr),
    .ext_wr_data(ext_wr_data), .ext_wr_mask(ext_wr_mask),
    .rd_rvalid(rd_rvalid), .rd_rsrc(rd_rsrc), .rd_data(rd_data), .ext_rd_data(ext_rd_data),
    .cnt_clear(cnt_clear), .cnt_access(cnt_access), .cnt_skip(cnt_skip), .addr_err(addr_err)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk(input int b, input int r);
    logic [1:0] bb;
    logic [6:0] rw;
    bb = b[1:0];
    rw = r[6:0];
    return {bb, rw, 2'b00};
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    int_rd_valid = 0; ext_rd_valid = 0; int_wr_valid = 0; ext_wr_valid = 0; cnt_clear = 0;
  endtask

  task automatic wr(input bit ext, input int b, input int r, input logic [31:0] d, input logic [3:0] m);
    if (ext) begin
      ext_wr_addr = mk(b, r); ext_wr_data = d; ext_wr_mask = m; ext_wr_valid = 1;
    end else begin
      int_wr_addr = mk(b, r); int_wr_data = d; int_wr_mask = m; int_wr_valid = 1;
    end
    step();
    ext_wr_valid = 0; int_wr_valid = 0;
  endtask

  task automatic rd(input bit ext, input int b, input int r);
    if (ext) begin ext_rd_addr = mk(b, r); ext_rd_valid = 1; end
    else begin int_rd_addr = mk(b, r); int_rd_valid = 1; end
    step();
    ext_rd_valid = 0; int_rd_valid = 0;
  endtask

  task automatic rd_chk(input string tag, input bit ext, input int b, input int r, input logic [31:0] exp);
    rd(ext, b, r);
    check({tag, "_vld"}, 32'(rd_rvalid), 1);
    check(tag, rd_data, exp);
  endtask

  task automatic clr();
    cnt_clear = 1;
    step();
    cnt_clear = 0;
  endtask

  initial begin
    idle();
    scan_en_in = 0; reset = 1;
    int_rd_addr = '0; ext_rd_addr = '0; int_wr_addr = '0; ext_wr_addr = '0;
    int_wr_data = '0; ext_wr_data = '0; int_wr_mask = '0; ext_wr_mask = '0;
    step();
    int_rd_valid = 1; ext_rd_valid = 1; int_wr_valid = 1; ext_wr_valid = 1;
    int_wr_mask = 4'hf; ext_wr_mask = 4'hf; ext_wr_addr = mk(1, 0);
    #1;
    check("rst_int_rd_rdy", 32'(int_rd_ready), 0);
    check("rst_ext_rd_rdy", 32'(ext_rd_ready), 0);
    check("rst_int_wr_rdy", 32'(int_wr_ready), 0);
    check("rst_ext_wr_rdy", 32'(ext_wr_ready), 0);
    step();
    idle();
    reset = 0;
    check("rst_rvalid", 32'(rd_rvalid), 0);
    check("rst_rdata", rd_data, 0);
    check("rst_err", 32'(addr_err), 0);
    check("rst_acc", 32'(cnt_access), 0);
    check("rst_skip", 32'(cnt_skip), 0);

    // RF contents are cleared by reset
    wr(1, 0, 5, 32'h44332211, 4'hf);
    rd_chk("rf_pre", 0, 0, 5, 32'h44332211);
    reset = 1;
    step();
    reset = 0;
    check("rf_rst_acc", 32'(cnt_access), 0);
    rd_chk("rf_rst_data", 0, 0, 5, 32'h0);

    // Same-bank write collision: external wins, internal completes next cycle
    clr();
    ext_wr_addr = mk(1, 70); ext_wr_data = 32'ha0a0a0a0; ext_wr_mask = 4'hf; ext_wr_valid = 1;
    int_wr_addr = mk(1, 71); int_wr_data = 32'hb1b1b1b1; int_wr_mask = 4'hf; int_wr_valid = 1;
    #1;
    check("coll_int_rdy", 32'(int_wr_ready), 0);
    check("coll_ext_rdy", 32'(ext_wr_ready), 1);
    step();
    ext_wr_valid = 0;
    #1;
    check("coll_int_rdy2", 32'(int_wr_ready), 1);
    step();
    int_wr_valid = 0;
    check("coll_acc", 32'(cnt_access), 2);
    rd_chk("coll_r70", 0, 1, 70, 32'ha0a0a0a0);
    rd_chk("coll_r71", 1, 1, 71, 32'hb1b1b1b1);

    // Different banks: both writes granted together
    clr();
    ext_wr_addr = mk(0, 80); ext_wr_data = 32'h80808080; ext_wr_mask = 4'hf; ext_wr_valid = 1;
    int_wr_addr = mk(1, 81); int_wr_data = 32'h81818181; int_wr_mask = 4'hf; int_wr_valid = 1;
    #1;
    check("par_int_rdy", 32'(int_wr_ready), 1);
    check("par_ext_rdy", 32'(ext_wr_ready), 1);
    step();
    idle();
    check("par_acc", 32'(cnt_access), 2);
    rd_chk("par_r80", 0, 0, 80, 32'h80808080);
    rd_chk("par_r81", 0, 1, 81, 32'h81818181);

    // Lane masks across the RF/SRAM boundary (row 63 in RF, row 64 in SRAM)
    wr(1, 0, 63, 32'h11223344, 4'hf);
    wr(0, 0, 64, 32'h11223344, 4'hf);
    wr(1, 0, 63, 32'haabbccdd, 4'b0101);
    wr(0, 0, 64, 32'haabbccdd, 4'b0101);
    rd_chk("mask_r63", 0, 0, 63, 32'h11bb33dd);
    rd_chk("mask_r64", 1, 0, 64, 32'h11bb33dd);
    rd_chk("mask_r63b", 0, 0, 63, 32'h11bb33dd);
    clr();
    wr(0, 0, 64, 32'hffffffff, 4'b0000);
    check("mask0_acc", 32'(cnt_access), 1);
    rd_chk("mask0_r64", 0, 0, 64, 32'h11bb33dd);

    // Read skip, then invalidation by a write to the held row
    wr(1, 1, 9, 32'h0badf00d, 4'hf);
    clr();
    rd_chk("skip_r1", 0, 1, 9, 32'h0badf00d);
    rd_chk("skip_r2", 0, 1, 9, 32'h0badf00d);
    rd_chk("skip_r3", 1, 1, 9, 32'h0badf00d);
    check("skip_cnt", 32'(cnt_skip), 2);
    check("skip_acc", 32'(cnt_access), 1);
    wr(1, 1, 9, 32'hcafe1234, 4'hf);
    rd_chk("skip_new", 0, 1, 9, 32'hcafe1234);
    check("skip_acc2", 32'(cnt_access), 3);
    check("skip_cnt2", 32'(cnt_skip), 2);

    // Reads stalled by a same-bank write, then external before internal
    wr(1, 0, 90, 32'h5a5a0001, 4'hf);
    wr(1, 0, 91, 32'h5a5a0002, 4'hf);
    int_wr_addr = mk(0, 92); int_wr_data = 32'h00000092; int_wr_mask = 4'hf; int_wr_valid = 1;
    ext_rd_addr = mk(0, 90); ext_rd_valid = 1;
    int_rd_addr = mk(0, 91); int_rd_valid = 1;
    #1;
    check("stall_wr_rdy", 32'(int_wr_ready), 1);
    check("stall_ext_rdy", 32'(ext_rd_ready), 0);
    check("stall_int_rdy", 32'(int_rd_ready), 0);
    step();
    int_wr_valid = 0;
    #1;
    check("prio_ext_rdy", 32'(ext_rd_ready), 1);
    check("prio_int_rdy", 32'(int_rd_ready), 0);
    check("prio_no_rvalid", 32'(rd_rvalid), 0);
    exp_q.push_back(32'h5a5a0001);
    exp_q.push_back(32'h5a5a0002);
    step();
    ext_rd_valid = 0;
    check("prio_ext_vld", 32'(rd_rvalid), 1);
    check("prio_ext_src", 32'(rd_rsrc), 1);
    check("prio_ext_data", rd_data, exp_q[0]);
    check("prio_ext_xdata", ext_rd_data, exp_q.pop_front());
    step();
    int_rd_valid = 0;
    check("prio_int_vld", 32'(rd_rvalid), 1);
    check("prio_int_src", 32'(rd_rsrc), 0);
    check("prio_int_data", rd_data, exp_q.pop_front());
    check("prio_int_xdata", ext_rd_data, 0);
    step();
    check("hold_out_vld", 32'(rd_rvalid), 0);
    check("hold_out_data", rd_data, 32'h5a5a0002);
    rd_chk("stall_wr_r92", 0, 0, 92, 32'h00000092);

    // Invalid bank index 3
    clr();
    rd(0, 3, 5);
    check("err_pulse", 32'(addr_err), 1);
    check("err_vld", 32'(rd_rvalid), 1);
    check("err_data", rd_data, 0);
    check("err_acc", 32'(cnt_access), 0);
    check("err_skip", 32'(cnt_skip), 0);
    step();
    check("err_pulse_end", 32'(addr_err), 0);
    wr(1, 3, 5, 32'hffffffff, 4'hf);
    check("err_wr_pulse", 32'(addr_err), 1);
    check("err_wr_acc", 32'(cnt_access), 0);

    // Counter saturation and clear priority
    clr();
    for (int i = 0; i < 20; i++) wr(1, 2, i, 32'(i), 4'hf);
    check("sat_acc", 32'(cnt_access), 15);
    cnt_clear = 1;
    ext_wr_addr = mk(2, 100); ext_wr_data = 32'h1; ext_wr_mask = 4'hf; ext_wr_valid = 1;
    step();
    idle();
    check("clr_over_inc", 32'(cnt_access), 0);

    // Reset arriving while a read result is pending discards it
    ext_rd_addr = mk(1, 9); ext_rd_valid = 1;
    step();
    ext_rd_valid = 0;
    reset = 1;
    #1;
    check("midrst_vld", 32'(rd_rvalid), 0);
    check("midrst_data", rd_data, 0);
    step();
    reset = 0;
    check("midrst_vld2", 32'(rd_rvalid), 0);
    check("midrst_data2", rd_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
